// File: rtl/layer_row_sequencer.sv
// Layer-pass row sequencer: walks rows row_first..row_last through the row multiplier,
// stores each row result in the result buffer and collects the per-row overflow mask.
module layer_row_sequencer #(
  parameter int NUM_ROWS = 16,
  parameter int RESULT_W = 32,
  parameter int TIMEOUT  = 2048,
  parameter int ROW_W    = $clog2(NUM_ROWS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  input  logic [ROW_W-1:0]    row_first,
  input  logic [ROW_W-1:0]    row_last,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [ROW_W-1:0]    row_select,
  output logic                begin_mult,
  input  logic                done_row,
  input  logic [RESULT_W-1:0] row_result,
  input  logic                overflow,
  output logic                res_wr_en,
  output logic [ROW_W-1:0]    res_wr_addr,
  output logic [RESULT_W-1:0] res_wr_data,
  output logic [NUM_ROWS-1:0] ovf_mask,
  output logic                ovf_any
);
  localparam int              TO_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_STORE, S_FIN} state_t;

  state_t              state_q, state_n;
  logic [ROW_W-1:0]    row_q, row_n, last_q, last_n;
  logic [TO_W-1:0]     tmo_q, tmo_n;
  logic                done_q, done_rise;
  logic                busy_n, done_n, err_n, begin_n, wr_en_n;
  logic [ROW_W-1:0]    row_sel_n, wr_addr_n;
  logic [RESULT_W-1:0] wr_data_n;
  logic [NUM_ROWS-1:0] mask_n;

  assign done_rise = done_row & ~done_q;

  // NOTE: every variable gets a default before the case so no path leaves one
  // unassigned; a missing default here would infer a latch.
  always_comb begin
    state_n   = state_q;
    row_n     = row_q;
    last_n    = last_q;
    tmo_n     = tmo_q;
    err_n     = err;
    row_sel_n = row_select;
    wr_addr_n = res_wr_addr;
    wr_data_n = res_wr_data;
    mask_n    = ovf_mask;
    begin_n   = 1'b0;
    wr_en_n   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          last_n = row_last;
          row_n  = row_first;
          err_n  = 1'b0;
          mask_n = '0;
          if (row_last < row_first) begin
            err_n   = 1'b1;
            state_n = S_FIN;
          end else begin
            state_n = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        begin_n   = 1'b1;
        row_sel_n = row_q;
        tmo_n     = '0;
        state_n   = S_WAIT;
      end
      S_WAIT: begin
        // tmo_q == 0 is the cycle begin_mult is high; a rise then is stale.
        if (done_rise && (tmo_q != '0)) begin
          wr_en_n   = 1'b1;
          wr_addr_n = row_q;
          wr_data_n = row_result;
          if (overflow) mask_n[row_q] = 1'b1;
          state_n   = S_STORE;
        end else if (tmo_q == TO_LAST) begin
          err_n   = 1'b1;
          state_n = S_FIN;
        end else begin
          tmo_n = tmo_q + 1'b1;
        end
      end
      S_STORE: begin
        if (row_q == last_q) begin
          state_n = S_FIN;
        end else begin
          row_n   = row_q + 1'b1;
          state_n = S_ISSUE;
        end
      end
      S_FIN:   state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase

    // Abort discards anything this cycle would have started; a write already
    // on the bus (STORE) has completed.
    if (abort && (state_q != S_IDLE)) begin
      state_n   = S_IDLE;
      begin_n   = 1'b0;
      wr_en_n   = 1'b0;
      err_n     = err;
      row_sel_n = row_select;
      wr_addr_n = res_wr_addr;
      wr_data_n = res_wr_data;
      mask_n    = ovf_mask;
    end

    busy_n = (state_n == S_ISSUE) || (state_n == S_WAIT) || (state_n == S_STORE);
    done_n = (state_n == S_FIN);
  end

  // NOTE: state and outputs use non-blocking assignments so every flop samples
  // the values from before this edge, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      row_q       <= '0;
      last_q      <= '0;
      tmo_q       <= '0;
      done_q      <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      row_select  <= '0;
      begin_mult  <= 1'b0;
      res_wr_en   <= 1'b0;
      res_wr_addr <= '0;
      res_wr_data <= '0;
      ovf_mask    <= '0;
      ovf_any     <= 1'b0;
    end else begin
      state_q     <= state_n;
      row_q       <= row_n;
      last_q      <= last_n;
      tmo_q       <= tmo_n;
      done_q      <= done_row;
      busy        <= busy_n;
      done        <= done_n;
      err         <= err_n;
      row_select  <= row_sel_n;
      begin_mult  <= begin_n;
      res_wr_en   <= wr_en_n;
      res_wr_addr <= wr_addr_n;
      res_wr_data <= wr_data_n;
      ovf_mask    <= mask_n;
      ovf_any     <= |mask_n;
    end
  end

endmodule
